// File: rtl/util_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : util_pkg
//  Description : Shared types and constants for the IF->ID fetched-packet path.
//                fetched_packet_t packs {pc, data, taken_branch} (65 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
package util_pkg;

   localparam int PC_BITS     = 32;
   localparam int INSTR_BITS  = 32;
   localparam int INSTR_COUNT = 2;
   localparam int FP_W        = PC_BITS + INSTR_BITS + 1;
   localparam int ACC_W       = $clog2(INSTR_COUNT + 1);

   typedef struct packed {
      logic [PC_BITS-1:0]    pc;
      logic [INSTR_BITS-1:0] data;
      logic                  taken_branch;
   } fetched_packet_t;

endpackage : util_pkg
`default_nettype wire

// File: rtl/id_fq_lane_mask.sv
`default_nettype none
// ============================================================================
//  Module      : id_fq_lane_mask
//  Description : Combinational lane filter for incoming fetch packets.
//                Keeps the contiguous run of valid lanes starting at lane 0,
//                up to and including the first predicted-taken lane.
//  Ports       : i_valid   - per-lane valid from IF
//                i_taken   - per-lane taken_branch bit
//                o_keep    - lanes to be written into the queue
//                o_acc_cnt - number of kept lanes
//  Revision    : 1.0 - initial release
// ============================================================================
module id_fq_lane_mask
   import util_pkg::*;
(
   input  logic [INSTR_COUNT-1:0] i_valid,
   input  logic [INSTR_COUNT-1:0] i_taken,
   output logic [INSTR_COUNT-1:0] o_keep,
   output logic [ACC_W-1:0]       o_acc_cnt
);

   logic w_stop;

   // A hole in valid or a taken branch terminates the kept run; the taken
   // lane itself survives because it is older than the redirect.
   always_comb begin
      w_stop    = 1'b0;
      o_keep    = '0;
      o_acc_cnt = '0;
      for (int k = 0; k < INSTR_COUNT; k++) begin
         if (!w_stop && i_valid[k]) begin
            o_keep[k] = 1'b1;
            o_acc_cnt = o_acc_cnt + ACC_W'(1);
            if (i_taken[k]) begin
               w_stop = 1'b1;
            end
         end else begin
            w_stop = 1'b1;
         end
      end
   end

endmodule : id_fq_lane_mask
`default_nettype wire

// File: rtl/id_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : id_fetch_queue
//  Description : Decode-stage input buffer. Accepts up to INSTR_COUNT fetched
//                lanes per cycle, drops lanes younger than a predicted-taken
//                branch, stores survivors in a circular FIFO and presents the
//                oldest INSTR_COUNT entries to decode. flush_i empties it.
//  Ports       : clk, rst   - clock, asynchronous active-high reset
//                valid_i    - per-lane valid from IF (contiguous from lane 0)
//                packet_i   - INSTR_COUNT packed fetched_packet_t lanes
//                ready_o    - room for a full INSTR_COUNT-lane packet
//                flush_i    - empty the queue, blocks same-cycle enq/deq
//                valid_o    - per-lane valid to decode, lane 0 oldest
//                packet_o   - oldest entries in lane order
//                ready_i    - decode consumes all valid_o lanes
//                count_o    - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module id_fetch_queue
   import util_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [INSTR_COUNT-1:0]        valid_i,
   input  logic [INSTR_COUNT*FP_W-1:0]   packet_i,
   output logic                          ready_o,
   input  logic                          flush_i,
   output logic [INSTR_COUNT-1:0]        valid_o,
   output logic [INSTR_COUNT*FP_W-1:0]   packet_o,
   input  logic                          ready_i,
   output logic [$clog2(DEPTH+1)-1:0]    count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_lanes = CNT_W'(INSTR_COUNT);

   fetched_packet_t         r_mem [DEPTH];
   logic [PTR_W-1:0]        r_head;
   logic [PTR_W-1:0]        r_tail;
   logic [CNT_W-1:0]        r_count;

   fetched_packet_t         w_pkt_in [INSTR_COUNT];
   logic [INSTR_COUNT-1:0]  w_taken;
   logic [INSTR_COUNT-1:0]  w_keep;
   logic [ACC_W-1:0]        w_acc_cnt;
   logic [ACC_W-1:0]        w_deq_cnt;
   logic [ACC_W-1:0]        w_acc;
   logic [ACC_W-1:0]        w_rem;
   logic                    w_enq;
   logic                    w_deq;

   generate
      for (genvar k = 0; k < INSTR_COUNT; k++) begin : g_lane_in
         assign w_pkt_in[k] = packet_i[k*FP_W +: FP_W];
         assign w_taken[k]  = w_pkt_in[k].taken_branch;
      end
   endgenerate

   id_fq_lane_mask u_lane_mask (
      .i_valid   (valid_i),
      .i_taken   (w_taken),
      .o_keep    (w_keep),
      .o_acc_cnt (w_acc_cnt)
   );

   // Free-space check uses only the registered count; a dequeue in the same
   // cycle does not open room for an enqueue.
   assign ready_o = (c_depth - r_count) >= c_lanes;
   assign w_enq   = ready_o && (|valid_i) && !flush_i;
   assign w_deq   = ready_i && valid_o[0] && !flush_i;
   assign count_o = r_count;

   generate
      for (genvar j = 0; j < INSTR_COUNT; j++) begin : g_lane_out
         assign valid_o[j]                = r_count > CNT_W'(j);
         assign packet_o[j*FP_W +: FP_W]  = r_mem[r_head + PTR_W'(j)];
      end
   endgenerate

   always_comb begin
      w_deq_cnt = '0;
      for (int j = 0; j < INSTR_COUNT; j++) begin
         w_deq_cnt = w_deq_cnt + ACC_W'(valid_o[j]);
      end
   end

   assign w_acc = w_enq ? w_acc_cnt : '0;
   assign w_rem = w_deq ? w_deq_cnt : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_rem);
         r_tail  <= r_tail + PTR_W'(w_acc);
         r_count <= r_count + CNT_W'(w_acc) - CNT_W'(w_rem);
      end
   end

   // Storage is not reset: entries beyond r_count are never presented.
   // Kept lanes form a prefix, so lane k lands at tail+k.
   always_ff @(posedge clk) begin
      for (int k = 0; k < INSTR_COUNT; k++) begin
         if (w_enq && w_keep[k]) begin
            r_mem[r_tail + PTR_W'(k)] <= w_pkt_in[k];
         end
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      r_count <= c_depth);

   a_enq_ready : assert property (@(posedge clk) disable iff (rst)
      w_enq |-> ready_o);

   a_valid_contig : assert property (@(posedge clk) disable iff (rst)
      (|valid_i) |-> ((valid_i & (valid_i + INSTR_COUNT'(1))) == '0));

   generate
      for (genvar j = 0; j < INSTR_COUNT; j++) begin : g_stable_chk
         a_out_stable : assert property (@(posedge clk) disable iff (rst)
            (valid_o[j] && !ready_i && !flush_i) |=> $stable(packet_o[j*FP_W +: FP_W]));
      end
   endgenerate

endmodule : id_fetch_queue
`default_nettype wire

// File: tb/tb_id_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_fetch_queue
//  Description : Directed self-checking bench for id_fetch_queue, followed by
//                a short randomized run against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_fetch_queue;
   import util_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                        clk;
   logic                        rst;
   logic [INSTR_COUNT-1:0]      valid_i;
   logic [INSTR_COUNT*FP_W-1:0] packet_i;
   logic                        ready_o;
   logic                        flush_i;
   logic [INSTR_COUNT-1:0]      valid_o;
   logic [INSTR_COUNT*FP_W-1:0] packet_o;
   logic                        ready_i;
   logic [CNT_W-1:0]            count_o;

   int n_cmp = 0;
   int n_err = 0;

   id_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_i),
      .packet_i (packet_i),
      .ready_o  (ready_o),
      .flush_i  (flush_i),
      .valid_o  (valid_o),
      .packet_o (packet_o),
      .ready_i  (ready_i),
      .count_o  (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FP_W-1:0] mk(input logic [31:0] pc, input logic tk);
      fetched_packet_t p;
      p.pc           = pc;
      p.data         = ~pc;
      p.taken_branch = tk;
      return p;
   endfunction

   task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic t0,
                        input logic [31:0] pc1, input logic t1);
      valid_i  = v;
      packet_i = {mk(pc1, t1), mk(pc0, t0)};
   endtask

   function automatic logic [31:0] pc_out(input int lane);
      logic [FP_W-1:0] p;
      p = packet_o[lane*FP_W +: FP_W];
      return p[FP_W-1 -: 32];
   endfunction

   function automatic logic [31:0] data_out(input int lane);
      logic [FP_W-1:0] p;
      p = packet_o[lane*FP_W +: FP_W];
      return p[32:1];
   endfunction

   logic [31:0] q_pc[$];
   logic [31:0] soak_pc;

   initial begin
      rst = 1'b1; valid_i = '0; packet_i = '0; flush_i = 1'b0; ready_i = 1'b0;
      tick(); tick();

      // 1. reset state, then first push
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      rst = 1'b0;
      tick();
      drive(2'b11, 32'h100, 1'b0, 32'h104, 1'b0);
      tick();
      valid_i = '0;
      chk("t1_valid", 32'(valid_o), 32'd3);
      chk("t1_pc0", pc_out(0), 32'h100);
      chk("t1_pc1", pc_out(1), 32'h104);
      chk("t1_data0", data_out(0), ~32'h100);
      ready_i = 1'b1; tick(); ready_i = 1'b0;
      chk("t1_drain", 32'(count_o), 32'd0);

      // 2. taken-branch masking
      drive(2'b11, 32'h200, 1'b1, 32'h204, 1'b0);
      tick();
      chk("t2_cnt_tk0", 32'(count_o), 32'd1);
      chk("t2_valid_tk0", 32'(valid_o), 32'd1);
      chk("t2_pc_tk0", pc_out(0), 32'h200);
      drive(2'b11, 32'h300, 1'b0, 32'h304, 1'b1);
      tick();
      valid_i = '0;
      chk("t2_cnt_tk1", 32'(count_o), 32'd3);
      chk("t2_pc1_tk1", pc_out(1), 32'h300);
      ready_i = 1'b1; tick();
      chk("t2_cnt_deq", 32'(count_o), 32'd1);
      chk("t2_pc_deq", pc_out(0), 32'h304);
      tick(); ready_i = 1'b0;
      chk("t2_empty", 32'(count_o), 32'd0);

      // 3. fill to full with decode stalled, then drain in order
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 32'h400 + 32'(i*8), 1'b0, 32'h404 + 32'(i*8), 1'b0);
         tick();
         chk("t3_fill_cnt", 32'(count_o), 32'(2*(i+1)));
         chk("t3_fill_rdy", 32'(ready_o), (i < 3) ? 32'd1 : 32'd0);
      end
      drive(2'b11, 32'h500, 1'b0, 32'h504, 1'b0);
      tick();
      chk("t3_held_cnt", 32'(count_o), 32'd8);
      chk("t3_held_pc0", pc_out(0), 32'h400);
      valid_i = '0; ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         if (i < 4) begin
            chk("t3_drain_pc0", pc_out(0), 32'h400 + 32'(i*8) - 32'h8);
         end
         tick();
         chk("t3_drain_cnt", 32'(count_o), 32'(8 - 2*i));
      end
      ready_i = 1'b0;

      // 4. count 7 blocks enqueue; enq+deq at count 5; wrap-around
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 32'h600 + 32'(i*8), 1'b0, 32'h604 + 32'(i*8), 1'b0);
         tick();
      end
      drive(2'b11, 32'h618, 1'b1, 32'h61c, 1'b0);
      tick();
      chk("t4_cnt7", 32'(count_o), 32'd7);
      chk("t4_rdy7", 32'(ready_o), 32'd0);
      drive(2'b11, 32'h680, 1'b0, 32'h684, 1'b0);
      ready_i = 1'b1;
      tick();
      chk("t4_deq_only", 32'(count_o), 32'd5);
      chk("t4_pc0_608", pc_out(0), 32'h608);
      drive(2'b11, 32'h700, 1'b0, 32'h704, 1'b0);
      tick();
      valid_i = '0;
      chk("t4_enqdeq_cnt", 32'(count_o), 32'd5);
      chk("t4_enqdeq_pc0", pc_out(0), 32'h610);
      tick();
      chk("t4_wrap_cnt", 32'(count_o), 32'd3);
      chk("t4_wrap_pc0", pc_out(0), 32'h618);
      chk("t4_wrap_pc1", pc_out(1), 32'h700);
      tick();
      chk("t4_last_pc0", pc_out(0), 32'h704);
      chk("t4_last_cnt", 32'(count_o), 32'd1);
      tick();
      ready_i = 1'b0;
      chk("t4_empty", 32'(count_o), 32'd0);

      // 5. flush beats same-cycle enqueue and dequeue
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 32'h800 + 32'(i*8), 1'b0, 32'h804 + 32'(i*8), 1'b0);
         tick();
      end
      chk("t5_cnt6", 32'(count_o), 32'd6);
      drive(2'b11, 32'h900, 1'b0, 32'h904, 1'b0);
      flush_i = 1'b1; ready_i = 1'b1;
      tick();
      flush_i = 1'b0; ready_i = 1'b0; valid_i = '0;
      chk("t5_flush_cnt", 32'(count_o), 32'd0);
      chk("t5_flush_valid", 32'(valid_o), 32'd0);
      drive(2'b11, 32'hA00, 1'b0, 32'hA04, 1'b0);
      tick();
      chk("t5_after_cnt", 32'(count_o), 32'd2);
      chk("t5_after_pc0", pc_out(0), 32'hA00);

      // 6. asynchronous reset mid-stream
      drive(2'b11, 32'hB00, 1'b0, 32'hB04, 1'b0);
      tick();
      valid_i = '0;
      chk("t6_cnt4", 32'(count_o), 32'd4);
      rst = 1'b1;
      #1;
      chk("t6_async_cnt", 32'(count_o), 32'd0);
      chk("t6_async_valid", 32'(valid_o), 32'd0);
      tick();
      rst = 1'b0;

      // randomized run against a queue model
      q_pc.delete();
      soak_pc = 32'h1000;
      for (int c = 0; c < 300; c++) begin
         logic [1:0] v;
         logic       t0, t1, rd, fl, mr;
         int         nd;
         chk("soak_cnt", 32'(count_o), 32'(q_pc.size()));
         chk("soak_rdy", 32'(ready_o), 32'((DEPTH - q_pc.size()) >= INSTR_COUNT));
         if (q_pc.size() > 0) chk("soak_pc0", pc_out(0), q_pc[0]);
         if (q_pc.size() > 1) chk("soak_pc1", pc_out(1), q_pc[1]);
         case ($urandom_range(0, 2))
            0:       v = 2'b00;
            1:       v = 2'b01;
            default: v = 2'b11;
         endcase
         t0 = ($urandom_range(0, 3) == 0);
         t1 = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 19) == 0);
         drive(v, soak_pc, t0, soak_pc + 32'd4, t1);
         ready_i = rd; flush_i = fl;
         mr = (DEPTH - q_pc.size()) >= INSTR_COUNT;
         if (fl) begin
            q_pc.delete();
         end else begin
            if (rd && q_pc.size() > 0) begin
               nd = (q_pc.size() < INSTR_COUNT) ? q_pc.size() : INSTR_COUNT;
               for (int d = 0; d < nd; d++) void'(q_pc.pop_front());
            end
            if (mr && v[0]) begin
               q_pc.push_back(soak_pc);
               if (v[1] && !t0) q_pc.push_back(soak_pc + 32'd4);
            end
         end
         soak_pc = soak_pc + 32'd8;
         tick();
      end
      valid_i = '0; ready_i = 1'b0; flush_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_id_fetch_queue
`default_nettype wire
